fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, which sets the address/PC width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, which is the first fetch address after reset.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port redirectE  in  1  control transfer (taken branch/JAL/JALR) resolved in Execute.
REQ-006 SHALL have port redirect_targetE  in  DATA_WIDTH  target of redirectE.
REQ-007 SHALL have port load_useD  in  1  load-use hazard detected in Decode.
REQ-008 SHALL have port imem_ready  in  1  instruction memory data valid; held high until accepted.
REQ-009 SHALL have port imem_req  out  1  fetch request; a transfer completes in any cycle with imem_req=1 and imem_ready=1.
REQ-010 SHALL have port pc_en  out  1  PC register write enable.
REQ-011 SHALL have port pc_sel  out  2  PC mux select: 00=PC+4, 01=pc_target, 10=RESET_VECTOR.
REQ-012 SHALL have port pc_target  out  DATA_WIDTH  redirect address presented to the PC mux.
REQ-013 SHALL have ports stallD, flushD and flushE  out  1 each  IF/ID hold, IF/ID clear and ID/EX clear.
REQ-014 SHALL have port fetch_valid  out  1  instruction accepted into IF/ID this cycle.
REQ-015 SHALL have port misalign  out  1  single-cycle pulse when an accepted redirect target has bit 1 set.
REQ-016 SHALL have ports redirect_cnt and stall_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, WAIT and PEND, with state-decoded outputs; any output not stated for a case is 0.
REQ-018 SHALL, in BOOT, drive pc_en=1, pc_sel=10, flushD=1, flushE=1 and imem_req=0, then go to FETCH unconditionally.
REQ-019 SHALL hold imem_req=1 in FETCH, WAIT and PEND.
REQ-020 SHALL, in FETCH, apply priority redirectE > load_useD > !imem_ready > normal.
- redirectE: pc_en=1, pc_sel=01, flushD=1, flushE=1; stay in FETCH.
- load_useD: pc_en=0, stallD=1, flushE=1; stay in FETCH.
- !imem_ready: pc_en=0, stallD=1; go to WAIT.
- normal: pc_en=1, pc_sel=00, fetch_valid=1.
REQ-021 SHALL, in WAIT, apply the following cases.
- redirectE: latch target, flushD=1, flushE=1, pc_en=0; go to PEND, because the PC is not changed while a fetch is outstanding.
- load_useD: stallD=1, flushE=1, pc_en=0; stay in WAIT.
- imem_ready: fetch_valid=1, pc_en=1, pc_sel=00; go to FETCH.
- otherwise: stallD=1; stay in WAIT.
REQ-022 SHALL, in PEND, drive fetch_valid=0 so the returning word is discarded.
- On imem_ready: pc_en=1, pc_sel=01 with pc_target = the latched target; go to FETCH.
- A further redirectE in PEND overwrites the latch and asserts flushD=1 and flushE=1.
REQ-023 SHALL drive pc_target from redirect_targetE in FETCH and from the latch in PEND, with bit 0 forced to 0 in both cases.
REQ-024 SHALL pulse misalign for one cycle when a redirect is accepted (pc_en=1 with pc_sel=01) and the target has bit 1 set; the redirect still proceeds.
REQ-025 SHALL never assert pc_en in the same cycle as stallD.

Reset
REQ-026 SHALL, while rst_n=0, force state=BOOT, clear the target latch and clear both counters; outputs then equal the BOOT outputs, with pc_target=0 and misalign=0.
REQ-027 SHALL, when reset is asserted mid-fetch (WAIT/PEND), abandon the outstanding request, so that any later imem_ready is ignored until FETCH is reached.

Configuration
REQ-028 SHALL implement the performance counters only when FETCH_CTRL_PERF_EN is defined.
- Defined: redirect_cnt increments by 1 on each accepted redirect; stall_cnt increments by 1 on each cycle with stallD=1; both wrap modulo 2^32.
- Undefined: the ports remain and are tied to 0, and no counter flops are built.

Verification
REQ-029 SHALL cover reset release: rst_n 0->1 with imem_ready=1 -> BOOT cycle (pc_sel=10, pc_en=1), then fetch_valid=1 and pc_sel=00 every cycle.
REQ-030 SHALL cover redirect in FETCH: redirectE=1, target=0x00000103 -> same cycle pc_sel=01, pc_target=0x00000102, flushD=flushE=1, misalign=1.
REQ-031 SHALL cover redirect during a wait: imem_ready=0 for 3 cycles, redirectE with 0x80 in cycle 2 -> PEND; on imem_ready, fetch_valid=0, pc_sel=01, pc_target=0x80.
REQ-032 SHALL cover simultaneous events: redirectE=1 and load_useD=1 in FETCH -> redirect wins (pc_en=1, stallD=0).
REQ-033 SHALL cover the counters: with FETCH_CTRL_PERF_EN defined, 2 load-use cycles plus 3 redirects -> stall_cnt=2, redirect_cnt=3; without the macro both read 0.
REQ-034 SHALL cover reset mid-operation: rst_n low while in WAIT -> the next cycle is BOOT and stall_cnt reads 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC mux/enable, IF/ID stall/flush and imem request.
// Optional perf counters are built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirectE,
    input  logic [DATA_WIDTH-1:0] redirect_targetE,
    input  logic                  load_useD,
    input  logic                  imem_ready,
    output logic                  imem_req,
    output logic                  pc_en,
    output logic [1:0]            pc_sel,
    output logic [DATA_WIDTH-1:0] pc_target,
    output logic                  stallD,
    output logic                  flushD,
    output logic                  flushE,
    output logic                  fetch_valid,
    output logic                  misalign,
    output logic [31:0]           redirect_cnt,
    output logic [31:0]           stall_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        WAIT  = 2'b10,
        PEND  = 2'b11
    } state_e;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_TGT = 2'b01;
    localparam logic [1:0] SEL_RST = 2'b10;

    if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_rv
        $error("RESET_VECTOR must be word aligned");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0] tgt_raw;
    logic                  redir_acc;

    // State register and redirect-target latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        tgt_raw     = '0;
        imem_req    = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = SEL_SEQ;
        stallD      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        fetch_valid = 1'b0;
        unique case (state_q)
            BOOT: begin
                pc_en   = 1'b1;
                pc_sel  = SEL_RST;
                flushD  = 1'b1;
                flushE  = 1'b1;
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                tgt_raw  = redirect_targetE;
                if (redirectE) begin
                    pc_en  = 1'b1;
                    pc_sel = SEL_TGT;
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (load_useD) begin
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else if (!imem_ready) begin
                    stallD  = 1'b1;
                    state_d = WAIT;
                end else begin
                    pc_en       = 1'b1;
                    fetch_valid = 1'b1;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (redirectE) begin
                    // PC stays put while a fetch is outstanding.
                    target_d = redirect_targetE;
                    flushD   = 1'b1;
                    flushE   = 1'b1;
                    state_d  = PEND;
                end else if (load_useD) begin
                    stallD = 1'b1;
                    flushE = 1'b1;
                end else if (imem_ready) begin
                    pc_en       = 1'b1;
                    fetch_valid = 1'b1;
                    state_d     = FETCH;
                end else begin
                    stallD = 1'b1;
                end
            end
            PEND: begin
                // Returning word belongs to the stale path; drop it.
                imem_req = 1'b1;
                tgt_raw  = target_q;
                if (redirectE) begin
                    target_d = redirect_targetE;
                    flushD   = 1'b1;
                    flushE   = 1'b1;
                end else if (imem_ready) begin
                    pc_en   = 1'b1;
                    pc_sel  = SEL_TGT;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign pc_target = {tgt_raw[DATA_WIDTH-1:1], 1'b0};
    assign redir_acc = pc_en && (pc_sel == SEL_TGT);
    assign misalign  = redir_acc && tgt_raw[1];

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] redirect_cnt_q, redirect_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments; wrap naturally at 2^32.
    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (redir_acc) redirect_cnt_d = redirect_cnt_q + 32'd1;
        if (stallD)    stall_cnt_d    = stall_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`else
    assign redirect_cnt = '0;
    assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver queues expected outputs,
// a negedge monitor pops and compares.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirectE;
    logic [31:0] redirect_targetE;
    logic        load_useD;
    logic        imem_ready;
    logic        imem_req;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic        fetch_valid;
    logic        misalign;
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirectE        (redirectE),
        .redirect_targetE (redirect_targetE),
        .load_useD        (load_useD),
        .imem_ready       (imem_ready),
        .imem_req         (imem_req),
        .pc_en            (pc_en),
        .pc_sel           (pc_sel),
        .pc_target        (pc_target),
        .stallD           (stallD),
        .flushD           (flushD),
        .flushE           (flushE),
        .fetch_valid      (fetch_valid),
        .misalign         (misalign),
        .redirect_cnt     (redirect_cnt),
        .stall_cnt        (stall_cnt)
    );

    typedef struct packed {
        logic        req;
        logic        en;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        st;
        logic        fd;
        logic        fe;
        logic        fv;
        logic        mis;
        logic [31:0] rc;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   idq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vid = 0;
    int   rc_m = 0;
    int   sc_m = 0;

    task automatic vec(
        input logic        rst,
        input logic        red,
        input logic [31:0] tg,
        input logic        lu,
        input logic        rdy,
        input logic        req,
        input logic        en,
        input logic [1:0]  sel,
        input logic [31:0] ptg,
        input logic        st,
        input logic        fd,
        input logic        fe,
        input logic        fv,
        input logic        mis
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = rst;
        redirectE        = red;
        redirect_targetE = tg;
        load_useD        = lu;
        imem_ready       = rdy;
        if (!rst) begin
            rc_m = 0;
            sc_m = 0;
        end
        e.req = req;
        e.en  = en;
        e.sel = sel;
        e.tgt = ptg;
        e.st  = st;
        e.fd  = fd;
        e.fe  = fe;
        e.fv  = fv;
        e.mis = mis;
`ifdef FETCH_CTRL_PERF_EN
        e.rc = rc_m;
        e.sc = sc_m;
`else
        e.rc = 32'd0;
        e.sc = 32'd0;
`endif
        vid++;
        q.push_back(e);
        idq.push_back(vid);
        if (st) sc_m++;
        if (en && sel == 2'b01) rc_m++;
    endtask

    // Monitor: compare the DUT outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        int   id;
        if (q.size() > 0) begin
            e  = q.pop_front();
            id = idq.pop_front();
            a.req = imem_req;
            a.en  = pc_en;
            a.sel = pc_sel;
            a.tgt = pc_target;
            a.st  = stallD;
            a.fd  = flushD;
            a.fe  = flushE;
            a.fv  = fetch_valid;
            a.mis = misalign;
            a.rc  = redirect_cnt;
            a.sc  = stall_cnt;
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL vec%0d got req=%b en=%b sel=%b tgt=%h st=%b fd=%b fe=%b fv=%b mis=%b rc=%0d sc=%0d want req=%b en=%b sel=%b tgt=%h st=%b fd=%b fe=%b fv=%b mis=%b rc=%0d sc=%0d",
                         id, a.req, a.en, a.sel, a.tgt, a.st, a.fd, a.fe,
                         a.fv, a.mis, a.rc, a.sc, e.req, e.en, e.sel,
                         e.tgt, e.st, e.fd, e.fe, e.fv, e.mis, e.rc, e.sc);
            end
        end
    end

    initial begin
        rst_n            = 1'b0;
        redirectE        = 1'b0;
        redirect_targetE = '0;
        load_useD        = 1'b0;
        imem_ready       = 1'b1;
        // reset and release into BOOT, then steady fetch
        vec(0, 0, 0, 0, 1,  0, 1, 2'b10, 0,  0, 1, 1, 0, 0);
        vec(0, 0, 0, 0, 1,  0, 1, 2'b10, 0,  0, 1, 1, 0, 0);
        vec(1, 0, 0, 0, 1,  0, 1, 2'b10, 0,  0, 1, 1, 0, 0);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b00, 0,  0, 0, 0, 1, 0);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b00, 0,  0, 0, 0, 1, 0);
        // redirect in FETCH, odd misaligned target
        vec(1, 1, 32'h103, 0, 1,  1, 1, 2'b01, 32'h102,  0, 1, 1, 0, 1);
        // redirect beats load-use
        vec(1, 1, 32'h200, 1, 1,  1, 1, 2'b01, 32'h200,  0, 1, 1, 0, 0);
        // two load-use cycles
        vec(1, 0, 0, 1, 1,  1, 0, 2'b00, 0,  1, 0, 1, 0, 0);
        vec(1, 0, 0, 1, 1,  1, 0, 2'b00, 0,  1, 0, 1, 0, 0);
        // wait, redirect during wait, pend, accept
        vec(1, 0, 0, 0, 0,  1, 0, 2'b00, 0,  1, 0, 0, 0, 0);
        vec(1, 1, 32'h80, 0, 0,  1, 0, 2'b00, 0,  0, 1, 1, 0, 0);
        vec(1, 0, 0, 0, 0,  1, 0, 2'b00, 32'h80,  0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b01, 32'h80,  0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b00, 0,  0, 0, 0, 1, 0);
        // wait with load-use, then ready
        vec(1, 0, 0, 0, 0,  1, 0, 2'b00, 0,  1, 0, 0, 0, 0);
        vec(1, 0, 0, 1, 0,  1, 0, 2'b00, 0,  1, 0, 1, 0, 0);
        vec(1, 0, 0, 0, 0,  1, 0, 2'b00, 0,  1, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b00, 0,  0, 0, 0, 1, 0);
        // redirect in PEND overwrites latch
        vec(1, 0, 0, 0, 0,  1, 0, 2'b00, 0,  1, 0, 0, 0, 0);
        vec(1, 1, 32'h10, 0, 0,  1, 0, 2'b00, 0,  0, 1, 1, 0, 0);
        vec(1, 1, 32'h46, 0, 0,  1, 0, 2'b00, 32'h10,  0, 1, 1, 0, 0);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b01, 32'h46,  0, 0, 0, 0, 1);
        // reset while in WAIT, ready ignored through BOOT
        vec(1, 0, 0, 0, 0,  1, 0, 2'b00, 0,  1, 0, 0, 0, 0);
        vec(0, 0, 0, 0, 1,  0, 1, 2'b10, 0,  0, 1, 1, 0, 0);
        vec(1, 0, 0, 0, 1,  0, 1, 2'b10, 0,  0, 1, 1, 0, 0);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b00, 0,  0, 0, 0, 1, 0);
        vec(1, 1, 32'h7, 0, 1,  1, 1, 2'b01, 32'h6,  0, 1, 1, 0, 1);
        vec(1, 0, 0, 0, 1,  1, 1, 2'b00, 0,  0, 0, 0, 1, 0);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
